// File: rtl/ovl_fire_collector.sv
// Collects per-checker fire pulses into pending flags and reports them one at a time, round-robin, over a valid/ready port.
// Optional statistics counters are built only when OVL_FIRE_COUNT_EN is defined; otherwise the counter ports read 0.
module ovl_fire_collector #(
    parameter int NUM_CHECKERS = 8,
    parameter int ID_WIDTH     = 3,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [NUM_CHECKERS-1:0] fire_in,
    output logic                    rpt_valid,
    input  logic                    rpt_ready,
    output logic [ID_WIDTH-1:0]     rpt_id,
    output logic                    overrun,
    output logic [CNT_WIDTH-1:0]    fire_count,
    output logic [CNT_WIDTH-1:0]    overrun_count
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0]              state;
    logic [NUM_CHECKERS-1:0] pending;
    logic [NUM_CHECKERS-1:0] fire_q;
    logic [NUM_CHECKERS-1:0] ack_mask;
    logic [NUM_CHECKERS-1:0] lost;
    logic [NUM_CHECKERS-1:0] pending_nxt;
    logic [ID_WIDTH-1:0]     last_id;

    // First set bit of req searching upward from last+1, wrapping at NUM_CHECKERS.
    function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_CHECKERS-1:0] req,
                                                    input logic [ID_WIDTH-1:0]     last);
        logic found;
        int   idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_CHECKERS; k++) begin
            idx = (int'(last) + 1 + k) % NUM_CHECKERS;
            if (!found && req[idx]) begin
                rr_pick = ID_WIDTH'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // A fire landing on the same edge its flag is acknowledged re-arms the flag instead of being lost.
    always_comb begin
        fire_q      = enable ? fire_in : '0;
        ack_mask    = (state == ST_PRESENT && rpt_ready) ? (NUM_CHECKERS'(1) << rpt_id) : '0;
        lost        = fire_q & pending & ~ack_mask;
        pending_nxt = (pending & ~ack_mask) | fire_q;
    end

    assign rpt_valid = (state == ST_PRESENT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            pending <= '0;
            rpt_id  <= '0;
            last_id <= ID_WIDTH'(NUM_CHECKERS - 1);
            overrun <= 1'b0;
        end else if (clear) begin
            state   <= ST_IDLE;
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= pending_nxt;
            overrun <= |lost;
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        rpt_id <= rr_pick(pending, last_id);
                        state  <= ST_PRESENT;
                    end
                end
                default: begin
                    if (rpt_ready) begin
                        last_id <= rpt_id;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef OVL_FIRE_COUNT_EN
    localparam int SUM_W = CNT_WIDTH + 6;

    logic [NUM_CHECKERS-1:0] accepted;
    logic [CNT_WIDTH-1:0]    fire_cnt_q;
    logic [CNT_WIDTH-1:0]    ovr_cnt_q;

    function automatic logic [SUM_W-1:0] popcount(input logic [NUM_CHECKERS-1:0] v);
        popcount = '0;
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            popcount = popcount + SUM_W'(v[i]);
        end
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [SUM_W-1:0]     b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + b;
        if (s > SUM_W'({CNT_WIDTH{1'b1}})) begin
            sat_add = '1;
        end else begin
            sat_add = s[CNT_WIDTH-1:0];
        end
    endfunction

    assign accepted = fire_q & ~lost;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fire_cnt_q <= '0;
            ovr_cnt_q  <= '0;
        end else if (clear) begin
            fire_cnt_q <= '0;
            ovr_cnt_q  <= '0;
        end else begin
            fire_cnt_q <= sat_add(fire_cnt_q, popcount(accepted));
            ovr_cnt_q  <= sat_add(ovr_cnt_q, popcount(lost));
        end
    end

    assign fire_count    = fire_cnt_q;
    assign overrun_count = ovr_cnt_q;
`else
    assign fire_count    = '0;
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Directed bench for ovl_fire_collector: default instance plus a CNT_WIDTH=2 instance for counter saturation.
module tb_ovl_fire_collector;

`ifdef OVL_FIRE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       clear;
    logic [7:0] fire_in;
    logic       rpt_ready;
    logic       rpt_valid;
    logic [2:0] rpt_id;
    logic       overrun;
    logic [7:0] fire_count;
    logic [7:0] overrun_count;
    logic       s_valid;
    logic [2:0] s_id;
    logic       s_overrun;
    logic [1:0] s_fire_count;
    logic [1:0] s_overrun_count;

    int checks = 0;
    int errors = 0;

    ovl_fire_collector #(.NUM_CHECKERS(8), .ID_WIDTH(3), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .fire_in(fire_in),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id), .overrun(overrun),
        .fire_count(fire_count), .overrun_count(overrun_count)
    );

    ovl_fire_collector #(.NUM_CHECKERS(8), .ID_WIDTH(3), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .fire_in(fire_in),
        .rpt_valid(s_valid), .rpt_ready(rpt_ready), .rpt_id(s_id), .overrun(s_overrun),
        .fire_count(s_fire_count), .overrun_count(s_overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset_n   = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        fire_in   = 8'h00;
        rpt_ready = 1'b1;
        cycle();
        cycle();
        #2;
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", rpt_valid); end
        checks++; if (rpt_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", rpt_id); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0h exp 0", overrun); end
        checks++; if (fire_count !== 8'd0) begin errors++; $display("FAIL reset_fire_count got %0d exp 0", fire_count); end
        checks++; if (overrun_count !== 8'd0) begin errors++; $display("FAIL reset_ovr_count got %0d exp 0", overrun_count); end
    endtask

    task automatic test_single();
        do_reset();
        fire_in = 8'h04;
        cycle();
        fire_in = 8'h00;
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL single_latency got %0h exp 0", rpt_valid); end
        cycle();
        checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h exp 1", rpt_valid); end
        checks++; if (rpt_id !== 3'd2) begin errors++; $display("FAIL single_id got %0d exp 2", rpt_id); end
        cycle();
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %0h exp 0", rpt_valid); end
        cycle();
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL single_stay_idle got %0h exp 0", rpt_valid); end
        checks++; if (fire_count !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL single_fire_count got %0d exp %0d", fire_count, CNT_EN ? 1 : 0); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            fire_in = 8'h81;
            cycle();
            fire_in = 8'h00;
            cycle();
            checks++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd0) begin errors++; $display("FAIL rr_first round %0d got v=%0h id=%0d exp v=1 id=0", r, rpt_valid, rpt_id); end
            cycle();
            checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL rr_gap round %0d got %0h exp 0", r, rpt_valid); end
            cycle();
            checks++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd7) begin errors++; $display("FAIL rr_second round %0d got v=%0h id=%0d exp v=1 id=7", r, rpt_valid, rpt_id); end
            cycle();
            checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL rr_done round %0d got %0h exp 0", r, rpt_valid); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rpt_ready = 1'b0;
        fire_in   = 8'h08;
        cycle();
        fire_in = 8'h00;
        cycle();
        checks++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd3) begin errors++; $display("FAIL bp_present got v=%0h id=%0d exp v=1 id=3", rpt_valid, rpt_id); end
        fire_in = 8'h08;
        cycle();
        fire_in = 8'h00;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_pulse got %0h exp 1", overrun); end
        checks++; if (rpt_id !== 3'd3) begin errors++; $display("FAIL bp_id_hold got %0d exp 3", rpt_id); end
        cycle();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun_single got %0h exp 0", overrun); end
        checks++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd3) begin errors++; $display("FAIL bp_still_held got v=%0h id=%0d exp v=1 id=3", rpt_valid, rpt_id); end
        checks++; if (overrun_count !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL bp_ovr_count got %0d exp %0d", overrun_count, CNT_EN ? 1 : 0); end
        checks++; if (fire_count !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL bp_fire_count got %0d exp %0d", fire_count, CNT_EN ? 1 : 0); end
        rpt_ready = 1'b1;
        cycle();
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %0h exp 0", rpt_valid); end
        cycle();
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL bp_no_repeat got %0h exp 0", rpt_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rpt_ready = 1'b0;
        fire_in   = 8'h20;
        cycle();
        fire_in = 8'h00;
        cycle();
        checks++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd5) begin errors++; $display("FAIL b2b_present got v=%0h id=%0d exp v=1 id=5", rpt_valid, rpt_id); end
        rpt_ready = 1'b1;
        fire_in   = 8'h20;
        cycle();
        rpt_ready = 1'b0;
        fire_in   = 8'h00;
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0h exp 0", rpt_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got %0h exp 0", overrun); end
        cycle();
        checks++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd5) begin errors++; $display("FAIL b2b_rereport got v=%0h id=%0d exp v=1 id=5", rpt_valid, rpt_id); end
        checks++; if (fire_count !== (CNT_EN ? 8'd2 : 8'd0)) begin errors++; $display("FAIL b2b_fire_count got %0d exp %0d", fire_count, CNT_EN ? 2 : 0); end
        checks++; if (overrun_count !== 8'd0) begin errors++; $display("FAIL b2b_ovr_count got %0d exp 0", overrun_count); end
        rpt_ready = 1'b1;
        cycle();
    endtask

    task automatic test_enable();
        do_reset();
        enable  = 1'b0;
        fire_in = 8'h10;
        cycle();
        fire_in = 8'h00;
        enable  = 1'b1;
        cycle();
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL enable_ignored got %0h exp 0", rpt_valid); end
        checks++; if (fire_count !== 8'd0) begin errors++; $display("FAIL enable_count got %0d exp 0", fire_count); end
    endtask

    task automatic test_reset_mid_report();
        do_reset();
        rpt_ready = 1'b0;
        fire_in   = 8'h02;
        cycle();
        fire_in = 8'h00;
        cycle();
        checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL rstmid_present got %0h exp 1", rpt_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async got %0h exp 0", rpt_valid); end
        checks++; if (fire_count !== 8'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", fire_count); end
        #2;
        reset_n = 1'b1;
        cycle();
        cycle();
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_not_represented got %0h exp 0", rpt_valid); end
        rpt_ready = 1'b1;
    endtask

    task automatic test_clear_mid_report();
        do_reset();
        rpt_ready = 1'b0;
        fire_in   = 8'h02;
        cycle();
        fire_in = 8'h00;
        cycle();
        checks++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd1) begin errors++; $display("FAIL clr_present got v=%0h id=%0d exp v=1 id=1", rpt_valid, rpt_id); end
        clear   = 1'b1;
        fire_in = 8'h03;
        cycle();
        clear   = 1'b0;
        fire_in = 8'h00;
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0h exp 0", rpt_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got %0h exp 0", overrun); end
        checks++; if (fire_count !== 8'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", fire_count); end
        cycle();
        cycle();
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL clr_pending_gone got %0h exp 0", rpt_valid); end
        rpt_ready = 1'b1;
    endtask

    task automatic test_saturation();
        logic [7:0] pat;
        int         exp_s;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pat     = 8'h01 << k;
            fire_in = pat;
            cycle();
            exp_s = CNT_EN ? ((k + 1 > 3) ? 3 : k + 1) : 0;
            checks++; if (s_fire_count !== 2'(exp_s)) begin errors++; $display("FAIL sat_count step %0d got %0d exp %0d", k, s_fire_count, exp_s); end
            checks++; if (fire_count !== (CNT_EN ? 8'(k + 1) : 8'd0)) begin errors++; $display("FAIL wide_count step %0d got %0d exp %0d", k, fire_count, CNT_EN ? k + 1 : 0); end
        end
        fire_in = 8'h00;
        for (int k = 0; k < 12; k++) cycle();
        checks++; if (s_fire_count !== (CNT_EN ? 2'd3 : 2'd0)) begin errors++; $display("FAIL sat_hold got %0d exp %0d", s_fire_count, CNT_EN ? 3 : 0); end
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL sat_drained got %0h exp 0", rpt_valid); end
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        fire_in   = 8'h00;
        rpt_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_enable();
        test_reset_mid_report();
        test_clear_mid_report();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
